// File: rtl/demux2_buf.sv
// demux2_buf: 1-to-2 stream demux, each output backed by a 2-entry FIFO.
// Define DEMUX2_CNT_EN to build the per-channel delivery counters.

module demux2_chan #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             full
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t             state;
    occ_t             state_nxt;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] head_nxt;
    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] tail_nxt;
    logic             pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

    // head only changes on a push into EMPTY, a replace, or a shift from tail,
    // so an empty channel keeps showing the last word it delivered
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        valid     = (state != EMPTY);
        full      = (state == FULL);
        pop       = valid & ready;
        case (state)
            EMPTY: begin
                if (push) begin
                    head_nxt  = din;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_nxt = din;
                end else if (push) begin
                    tail_nxt  = din;
                    state_nxt = FULL;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_nxt  = tail;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    assign data = head;

endmodule

module demux2_buf #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Z,
    input  logic             s,
    input  logic             z_valid,
    output logic             z_ready,
    output logic [WIDTH-1:0] A,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] B,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_cnt,
    output logic [CNT_W-1:0] b_cnt
);

    logic a_full;
    logic b_full;
    logic sel_full;
    logic xfer;
    logic push_a;
    logic push_b;

    // ready looks only at the targeted channel, never at sink readies
    assign sel_full = s ? b_full : a_full;
    assign z_ready  = rst_n & ~sel_full;
    assign xfer     = z_valid & z_ready;
    assign push_a   = xfer & ~s;
    assign push_b   = xfer & s;

    demux2_chan #(
        .WIDTH(WIDTH)
    ) u_chan_a (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push_a),
        .din  (Z),
        .ready(a_ready),
        .data (A),
        .valid(a_valid),
        .full (a_full)
    );

    demux2_chan #(
        .WIDTH(WIDTH)
    ) u_chan_b (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push_b),
        .din  (Z),
        .ready(b_ready),
        .data (B),
        .valid(b_valid),
        .full (b_full)
    );

`ifdef DEMUX2_CNT_EN
    logic [CNT_W-1:0] a_cnt_q;
    logic [CNT_W-1:0] b_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            if (a_valid && a_ready) begin
                a_cnt_q <= a_cnt_q + CNT_W'(1);
            end
            if (b_valid && b_ready) begin
                b_cnt_q <= b_cnt_q + CNT_W'(1);
            end
        end
    end

    assign a_cnt = a_cnt_q;
    assign b_cnt = b_cnt_q;
`else
    assign a_cnt = '0;
    assign b_cnt = '0;
`endif

endmodule

// File: tb/tb_demux2_buf.sv
// Bench for demux2_buf: queue-based reference model plus directed
// literal checks, followed by a constrained-random phase.

module tb_demux2_buf;

    localparam int W  = 32;
    localparam int CW = 4;
`ifdef DEMUX2_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  Z = '0;
    logic          s = 1'b0;
    logic          z_valid = 1'b0;
    logic          z_ready;
    logic [W-1:0]  A;
    logic          a_valid;
    logic          a_ready = 1'b0;
    logic [W-1:0]  B;
    logic          b_valid;
    logic          b_ready = 1'b0;
    logic [CW-1:0] a_cnt;
    logic [CW-1:0] b_cnt;

    demux2_buf #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Z      (Z),
        .s      (s),
        .z_valid(z_valid),
        .z_ready(z_ready),
        .A      (A),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .B      (B),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .a_cnt  (a_cnt),
        .b_cnt  (b_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // reference model: one queue per channel, updated at each rising edge
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] last_a = '0;
    logic [W-1:0] last_b = '0;
    int           m_acnt = 0;
    int           m_bcnt = 0;
    bit           started = 1'b0;
    bit           acc_last = 1'b0;

    always @(posedge clk) begin
        started  = 1'b1;
        acc_last = 1'b0;
        if (!rst_n) begin
            qa.delete();
            qb.delete();
            last_a = '0;
            last_b = '0;
            m_acnt = 0;
            m_bcnt = 0;
        end else begin
            bit pa;
            bit pb;
            bit zr;
            zr = s ? (qb.size() < 2) : (qa.size() < 2);
            pa = (qa.size() > 0) && a_ready;
            pb = (qb.size() > 0) && b_ready;
            if (qa.size() > 0) last_a = qa[0];
            if (qb.size() > 0) last_b = qb[0];
            if (pa) begin
                void'(qa.pop_front());
                if (CNT_ON) m_acnt = (m_acnt + 1) % (1 << CW);
            end
            if (pb) begin
                void'(qb.pop_front());
                if (CNT_ON) m_bcnt = (m_bcnt + 1) % (1 << CW);
            end
            if (z_valid && zr) begin
                acc_last = 1'b1;
                if (s) qb.push_back(Z);
                else qa.push_back(Z);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_z_ready", {31'd0, z_ready},
                {31'd0, rst_n && (s ? (qb.size() < 2) : (qa.size() < 2))});
            chk("m_a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
            chk("m_b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
            chk("m_A", A, (qa.size() != 0) ? qa[0] : last_a);
            chk("m_B", B, (qb.size() != 0) ? qb[0] : last_b);
            chk("m_a_cnt", {28'd0, a_cnt}, m_acnt[31:0]);
            chk("m_b_cnt", {28'd0, b_cnt}, m_bcnt[31:0]);
        end
    end

    bit           rec = 1'b0;
    logic [W-1:0] got[$];

    always @(negedge clk) begin
        if (rec && a_valid && a_ready) got.push_back(A);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(output int n);
        n = 0;
        while (1) begin
            step();
            n++;
            if (acc_last) break;
            if (n >= 20) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: got none expected accept");
                break;
            end
        end
        z_valid = 1'b0;
    endtask

    task automatic push_word(input logic [W-1:0] d, input logic sel,
                             output int n);
        Z       = d;
        s       = sel;
        z_valid = 1'b1;
        wait_acc(n);
    endtask

    task automatic pulse_rst();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    int n;

    initial begin
        // reset held with a word offered
        rst_n   = 1'b0;
        z_valid = 1'b1;
        Z       = 32'h1234_5678;
        s       = 1'b0;
        a_ready = 1'b1;
        b_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_z_ready", {31'd0, z_ready}, 32'd0);
            chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
            chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
            chk("rst_A", A, 32'd0);
            chk("rst_B", B, 32'd0);
            chk("rst_cnt", {24'd0, a_cnt, b_cnt}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        z_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_z_ready", {31'd0, z_ready}, 32'd1);
        step();

        // steering
        push_word(32'hAAAA_AAAA, 1'b0, n);
        @(negedge clk);
        chk("steer_A", A, 32'hAAAA_AAAA);
        chk("steer_a_valid", {31'd0, a_valid}, 32'd1);
        chk("steer_b_quiet", {31'd0, b_valid}, 32'd0);
        step();
        push_word(32'hBBBB_BBBB, 1'b1, n);
        @(negedge clk);
        chk("steer_B", B, 32'hBBBB_BBBB);
        chk("steer_b_valid", {31'd0, b_valid}, 32'd1);
        chk("steer_a_done", {31'd0, a_valid}, 32'd0);
        step();

        // backpressure on A
        a_ready = 1'b0;
        push_word(32'hCCCC_CCCC, 1'b0, n);
        push_word(32'hDDDD_DDDD, 1'b0, n);
        Z       = 32'hEEEE_EEEE;
        s       = 1'b0;
        z_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("full_z_ready", {31'd0, z_ready}, 32'd0);
            chk("full_hold_A", A, 32'hCCCC_CCCC);
            step();
        end
        got.delete();
        rec     = 1'b1;
        a_ready = 1'b1;
        wait_acc(n);
        chk("full_accept_wait", n, 32'd2);
        repeat (4) step();
        rec = 1'b0;
        chk("drain_count", got.size(), 32'd3);
        chk("drain_0", (got.size() > 0) ? got[0] : 32'd0, 32'hCCCC_CCCC);
        chk("drain_1", (got.size() > 1) ? got[1] : 32'd0, 32'hDDDD_DDDD);
        chk("drain_2", (got.size() > 2) ? got[2] : 32'd0, 32'hEEEE_EEEE);

        // isolation: A full and stalled, B still flows
        a_ready = 1'b0;
        push_word(32'h1111_1111, 1'b0, n);
        push_word(32'h2222_2222, 1'b0, n);
        push_word(32'hFFFF_FFFF, 1'b1, n);
        chk("iso_latency", n, 32'd1);
        @(negedge clk);
        chk("iso_B", B, 32'hFFFF_FFFF);
        chk("iso_b_valid", {31'd0, b_valid}, 32'd1);
        chk("iso_A_held", A, 32'h1111_1111);
        step();
        a_ready = 1'b1;
        repeat (4) step();

        // streaming, alternating channels
        pulse_rst();
        for (int i = 0; i < 20; i++) begin
            push_word(32'h5000_0000 + i, i[0], n);
            chk("stream_latency", n, 32'd1);
        end
        repeat (3) step();
        @(negedge clk);
        chk("stream_a_cnt", {28'd0, a_cnt}, CNT_ON ? 32'd10 : 32'd0);
        chk("stream_b_cnt", {28'd0, b_cnt}, CNT_ON ? 32'd10 : 32'd0);
        step();

        // counter wrap, then reset with a word buffered
        pulse_rst();
        for (int i = 0; i < 17; i++) begin
            push_word(32'h7000_0000 + i, 1'b0, n);
        end
        repeat (3) step();
        @(negedge clk);
        chk("wrap_a_cnt", {28'd0, a_cnt}, CNT_ON ? 32'd1 : 32'd0);
        step();
        a_ready = 1'b0;
        push_word(32'h7777_7777, 1'b0, n);
        pulse_rst();
        @(negedge clk);
        chk("midrst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("midrst_a_cnt", {28'd0, a_cnt}, 32'd0);
        chk("midrst_A", A, 32'd0);
        step();

        // random traffic; producer holds Z/s until accepted
        repeat (3000) begin
            if (!(z_valid && !acc_last)) begin
                z_valid = ($urandom % 4) != 0;
                Z       = $urandom;
                s       = $urandom % 2;
            end
            a_ready = ($urandom % 3) != 0;
            b_ready = ($urandom % 3) != 0;
            rst_n   = ($urandom % 300) != 0;
            step();
        end
        rst_n   = 1'b1;
        z_valid = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
